// File: rtl/alarm_ctrl.sv
// Alarm sequencing controller: arm/disarm, ring with auto-stop, stop, and BCD snooze.
// Optional build macro ALARM_CTRL_LED_EN adds the alarm_led status output.
module alarm_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int RING_SECS       = 60,
  parameter int SNOOZE_MIN      = 5,
  parameter int MAX_SNOOZE      = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sec_tick,
  input  logic [3:0] h_cntH,
  input  logic [3:0] h_cntL,
  input  logic [3:0] m_cntH,
  input  logic [3:0] m_cntL,
  input  logic [3:0] s_cntH,
  input  logic [3:0] s_cntL,
  input  logic [7:0] set_hr,
  input  logic [7:0] set_min,
  input  logic       arm_key,
  input  logic       stop_key,
  input  logic       snooze_key,
  output logic       CtrlBell,
  output logic [1:0] bell_state,
  output logic [7:0] snooze_hr,
  output logic [7:0] snooze_min
`ifdef ALARM_CTRL_LED_EN
  ,
  output logic       alarm_led
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [7:0]       RING_LAST = 8'(RING_SECS - 1);
  localparam logic [2:0]       SNZ_MAX   = 3'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    DISARMED = 2'b00,
    ARMED    = 2'b01,
    RINGING  = 2'b10,
    SNOOZING = 2'b11
  } state_t;

  function automatic logic [7:0] bcdToBin(input logic [3:0] tens, input logic [3:0] units);
    return 8'(tens) * 8'd10 + 8'(units);
  endfunction

  function automatic logic [7:0] binToBcd(input logic [7:0] v);
    logic [3:0] tens;
    logic [7:0] rem;
    tens = '0;
    rem  = v;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 8'd10) begin
        rem  = rem - 8'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  // Key conditioning: synchronizer, consecutive-high counter, single press pulse
  logic [2:0]       rawKeys, sync1, sync2, pressPulse;
  logic [CNT_W-1:0] debCnt [3];

  assign rawKeys = {snooze_key, stop_key, arm_key};

  // Synchronizers and counters start saturated so a key held across reset must be released first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1      <= '1;
      sync2      <= '1;
      pressPulse <= '0;
      for (int k = 0; k < 3; k++) debCnt[k] <= DEB_MAX;
    end else begin
      sync1 <= rawKeys;
      sync2 <= sync1;
      for (int k = 0; k < 3; k++) begin
        if (!sync2[k]) begin
          debCnt[k]     <= '0;
          pressPulse[k] <= 1'b0;
        end else begin
          if (debCnt[k] != DEB_MAX) debCnt[k] <= debCnt[k] + CNT_W'(1);
          pressPulse[k] <= (debCnt[k] == DEB_MAX - CNT_W'(1));
        end
      end
    end
  end

  logic armPress, stopPress, snoozePress;
  assign armPress    = pressPulse[0];
  assign stopPress   = pressPulse[1];
  assign snoozePress = pressPulse[2];

  // Alarm match and snooze target arithmetic
  state_t     state, stateNext;
  logic [7:0] tgtHr, tgtMin, minAdj, hrAdj;
  logic       match;

  assign tgtHr  = (state == SNOOZING) ? snooze_hr  : set_hr;
  assign tgtMin = (state == SNOOZING) ? snooze_min : set_min;
  assign match  = sec_tick && ({h_cntH, h_cntL} == tgtHr) && ({m_cntH, m_cntL} == tgtMin)
                  && (s_cntH == 4'd0) && (s_cntL == 4'd0);

  always_comb begin
    minAdj = bcdToBin(m_cntH, m_cntL) + 8'(SNOOZE_MIN);
    hrAdj  = bcdToBin(h_cntH, h_cntL);
    if (minAdj >= 8'd60) begin
      minAdj = minAdj - 8'd60;
      hrAdj  = (hrAdj >= 8'd23) ? 8'd0 : hrAdj + 8'd1;
    end
  end

  // Sequencing FSM
  logic [7:0] ringCnt, ringCntNext, snoozeHrNext, snoozeMinNext;
  logic [2:0] snoozeCnt, snoozeCntNext;

  always_comb begin
    stateNext     = state;
    ringCntNext   = ringCnt;
    snoozeCntNext = snoozeCnt;
    snoozeHrNext  = snooze_hr;
    snoozeMinNext = snooze_min;
    case (state)
      DISARMED: if (armPress) stateNext = ARMED;
      ARMED: begin
        if (armPress) stateNext = DISARMED;
        else if (match) begin
          stateNext     = RINGING;
          ringCntNext   = '0;
          snoozeCntNext = '0;
        end
      end
      RINGING: begin
        if (armPress) stateNext = DISARMED;
        else if (stopPress) stateNext = ARMED;
        else if (snoozePress && (snoozeCnt < SNZ_MAX)) begin
          stateNext     = SNOOZING;
          snoozeCntNext = snoozeCnt + 3'd1;
          snoozeHrNext  = binToBcd(hrAdj);
          snoozeMinNext = binToBcd(minAdj);
        end else if (sec_tick) begin
          if (ringCnt == RING_LAST) stateNext = ARMED;
          else ringCntNext = ringCnt + 8'd1;
        end
      end
      SNOOZING: begin
        if (armPress) stateNext = DISARMED;
        else if (stopPress) stateNext = ARMED;
        else if (match) begin
          stateNext   = RINGING;
          ringCntNext = '0;
        end
      end
      default: stateNext = DISARMED;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= DISARMED;
      ringCnt    <= '0;
      snoozeCnt  <= '0;
      snooze_hr  <= 8'h00;
      snooze_min <= 8'h00;
      CtrlBell   <= 1'b0;
    end else begin
      state      <= stateNext;
      ringCnt    <= ringCntNext;
      snoozeCnt  <= snoozeCntNext;
      snooze_hr  <= snoozeHrNext;
      snooze_min <= snoozeMinNext;
      CtrlBell   <= (stateNext == RINGING);
    end
  end

  assign bell_state = state;

`ifdef ALARM_CTRL_LED_EN
  // Blinks while snoozing, starting lit on entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) alarm_led <= 1'b0;
    else begin
      case (stateNext)
        DISARMED: alarm_led <= 1'b0;
        SNOOZING: alarm_led <= (state != SNOOZING) ? 1'b1 : (alarm_led ^ sec_tick);
        default:  alarm_led <= 1'b1;
      endcase
    end
  end
`endif

endmodule
